// File: rtl/compare_search_pkg.sv
// compare_search_pkg
//   Shared types for the comparator-driven binary search:
//     state_e : search controller states (IDLE, PROBE, DONE)
//     resp_e  : decoded comparator response (RESP_LT, RESP_GT, RESP_EQ, RESP_BAD)
package compare_search_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RESP_LT  = 2'd0,
    RESP_GT  = 2'd1,
    RESP_EQ  = 2'd2,
    RESP_BAD = 2'd3
  } resp_e;

endpackage

// File: rtl/compare_search_resp_decode.sv
// cmp_resp_decode
//   Maps the external comparator flags to a single response code.
//   Ports:
//     l, g, e : comparator flags (cand<target, cand>target, cand==target)
//     resp    : RESP_LT / RESP_GT / RESP_EQ when exactly one flag is high,
//               RESP_BAD for none or more than one
module cmp_resp_decode
  import compare_search_pkg::*;
(
  input  logic  l,
  input  logic  g,
  input  logic  e,
  output resp_e resp
);

  always_comb begin
    resp = RESP_BAD;
    case ({l, g, e})
      3'b100:  resp = RESP_LT;
      3'b010:  resp = RESP_GT;
      3'b001:  resp = RESP_EQ;
      default: resp = RESP_BAD;
    endcase
  end

endmodule

// File: rtl/compare_search.sv
// compare_search
//   Binary search for a hidden target using an external comparator.
//   Optional feature macro: SEARCH_PROBE_CNT_EN (adds the probes output).
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     start         : begin a search (only honoured in IDLE)
//     cand          : current probe value presented to the comparator
//     l, g, e       : comparator response for cand vs target
//     busy          : high while probing
//     done          : one-cycle pulse when a search ends
//     found, err    : outcome flags, held until the next start
//     result        : located value, held until the next start
//     probes        : (SEARCH_PROBE_CNT_EN only) responses sampled this search
module compare_search
  import compare_search_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] cand,
  input  logic             l,
  input  logic             g,
  input  logic             e,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result
`ifdef SEARCH_PROBE_CNT_EN
  ,
  output logic [$clog2(WIDTH+2)-1:0] probes
`endif
);

  localparam logic [WIDTH-1:0] MAX_V = '1;
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  // Sum is formed one bit wider so lo=hi=MAX cannot wrap.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] lo,
                                                input logic [WIDTH-1:0] hi);
    logic [WIDTH:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return sum[WIDTH:1];
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             found_q, found_d;
  logic             err_q, err_d;
  resp_e            resp;

`ifdef SEARCH_PROBE_CNT_EN
  localparam int unsigned PW = $clog2(WIDTH+2);
  logic [PW-1:0] probes_q, probes_d;
`endif

  cmp_resp_decode u_decode (
    .l    (l),
    .g    (g),
    .e    (e),
    .resp (resp)
  );

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cand_d   = cand_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
`ifdef SEARCH_PROBE_CNT_EN
    probes_d = probes_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = MAX_V;
          cand_d   = midpoint('0, MAX_V);
          result_d = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          state_d  = PROBE;
`ifdef SEARCH_PROBE_CNT_EN
          probes_d = '0;
`endif
        end
      end
      PROBE: begin
`ifdef SEARCH_PROBE_CNT_EN
        probes_d = probes_q + PW'(1);
`endif
        case (resp)
          RESP_EQ: begin
            result_d = cand_q;
            found_d  = 1'b1;
            state_d  = DONE;
          end
          RESP_LT: begin
            if (cand_q == MAX_V) begin
              err_d   = 1'b1;
              found_d = 1'b0;
              state_d = DONE;
            end else begin
              lo_d   = cand_q + ONE_V;
              cand_d = midpoint(cand_q + ONE_V, hi_q);
            end
          end
          RESP_GT: begin
            if (cand_q == '0) begin
              err_d   = 1'b1;
              found_d = 1'b0;
              state_d = DONE;
            end else begin
              hi_d   = cand_q - ONE_V;
              cand_d = midpoint(lo_q, cand_q - ONE_V);
            end
          end
          default: begin
            err_d   = 1'b1;
            found_d = 1'b0;
            state_d = DONE;
          end
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      cand_q   <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef SEARCH_PROBE_CNT_EN
      probes_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      cand_q   <= cand_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
`ifdef SEARCH_PROBE_CNT_EN
      probes_q <= probes_d;
`endif
    end
  end

  assign cand   = cand_q;
  assign result = result_q;
  assign found  = found_q;
  assign err    = err_q;
  assign busy   = (state_q == PROBE);
  assign done   = (state_q == DONE);
`ifdef SEARCH_PROBE_CNT_EN
  assign probes = probes_q;
`endif

endmodule

// File: tb/tb_compare_search.sv
// tb_compare_search
//   Closes the loop with a behavioural comparator and checks each search
//   against a reference binary search computed with integer arithmetic.
module tb_compare_search;

  localparam int unsigned W = 3;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst, start, l, g, e;
  logic [W-1:0] cand, result;
  logic         busy, done, found, err;
`ifdef SEARCH_PROBE_CNT_EN
  logic [$clog2(W+2)-1:0] probes;
`endif

  int target;
  bit force_bad;
  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int obs_q[$];

  always #5 clk = ~clk;

  compare_search #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cand   (cand),
    .l      (l),
    .g      (g),
    .e      (e),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .err    (err),
    .result (result)
`ifdef SEARCH_PROBE_CNT_EN
    ,
    .probes (probes)
`endif
  );

  // Behavioural comparator, optionally forced to an illegal l=g=1 answer.
  always_comb begin
    if (force_bad) begin
      l = 1'b1; g = 1'b1; e = 1'b0;
    end else begin
      l = (int'(cand) < target);
      g = (int'(cand) > target);
      e = (int'(cand) == target);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: textbook binary search over [0, MAXV].
  task automatic build_model(input int t);
    int lo, hi, m;
    exp_q.delete();
    lo = 0;
    hi = MAXV;
    for (int i = 0; i < 16; i++) begin
      m = (lo + hi) / 2;
      exp_q.push_back(m);
      if (m == t) break;
      if (m < t) lo = m + 1;
      else hi = m - 1;
    end
  endtask

  task automatic run_search(input int t, input string tag);
    int cycles;
    target = t;
    build_model(t);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    obs_q.delete();
    cycles = 0;
    while (!done && cycles < 20) begin
      if (busy) obs_q.push_back(int'(cand));
      @(negedge clk);
      cycles++;
    end
    check({tag, "_done_seen"}, int'(done), 1);
    check({tag, "_nprobes"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_cand%0d", tag, i), obs_q[i], exp_q[i]);
    check({tag, "_found"}, int'(found), 1);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_result"}, int'(result), t);
`ifdef SEARCH_PROBE_CNT_EN
    check({tag, "_probes"}, int'(probes), exp_q.size());
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_found_held"}, int'(found), 1);
    check({tag, "_result_held"}, int'(result), t);
  endtask

  initial begin
    int dones, p, wait_cnt;
    bit prev_done, consec;

    rst = 1'b1; start = 1'b0; force_bad = 1'b0; target = 0;
    repeat (2) @(negedge clk);
    check("rst_cand", int'(cand), 0);
    check("rst_result", int'(result), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_found", int'(found), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    @(negedge clk);

    run_search(5, "t5");
    run_search(7, "t7");
    run_search(0, "t0");
    for (int k = 0; k < 8; k++)
      run_search(int'($urandom_range(0, MAXV)), $sformatf("rnd%0d", k));

    // Illegal l=g=1 on the first probe aborts with err.
    target = 6;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("bad_busy", int'(busy), 1);
    force_bad = 1'b1;
    @(negedge clk);
    check("bad_done", int'(done), 1);
    check("bad_err", int'(err), 1);
    check("bad_found", int'(found), 0);
    force_bad = 1'b0;
    @(negedge clk);
    check("bad_done_pulse", int'(done), 0);
    check("bad_err_held", int'(err), 1);

    // Reset during the second probe of a target=6 search.
    target = 6;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    check("rstmid_cand2", int'(cand), 5);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_cand", int'(cand), 0);
    check("rstmid_found", int'(found), 0);
    check("rstmid_err", int'(err), 0);
    check("rstmid_result", int'(result), 0);
    dones = int'(done);
    repeat (4) begin
      @(negedge clk);
      dones += int'(done);
    end
    check("rstmid_no_done", dones, 0);
    run_search(6, "after_rst");

    // Reset wins over a simultaneous start.
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_prio_busy", int'(busy), 0);
    @(negedge clk);

    // start held high: one search per IDLE entry, single-cycle done each.
    target = 7;
    build_model(7);
    p = exp_q.size();
    start = 1'b1;
    dones = 0; prev_done = 1'b0; consec = 1'b0;
    repeat (3 * (p + 2)) begin
      @(negedge clk);
      if (done) dones++;
      if (done && prev_done) consec = 1'b1;
      prev_done = done;
    end
    start = 1'b0;
    wait_cnt = 0;
    while ((busy || done) && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("held_done_count", dones, 3);
    check("held_done_consec", int'(consec), 0);
    check("held_idle", int'(busy || done), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
